// File: rtl/go_pkg.sv
// go_pkg: shared board cell codes, address width and scan FSM states.
package go_pkg;
  localparam int BOARD_ADDR_W = 6;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_INVALID = 2'b11;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} scan_state_t;
endpackage

// File: rtl/board_scan_stone_tally.sv
// stone_tally: counts empty/black/white codes on each valid strobe, flags reserved codes.
module stone_tally
  import go_pkg::*;
#(
  parameter int CNT_W = BOARD_ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [1:0]       code,
  output logic [CNT_W-1:0] empty_cnt,
  output logic [CNT_W-1:0] black_cnt,
  output logic [CNT_W-1:0] white_cnt,
  output logic             invalid
);
  always_ff @(posedge clk)
    if (rst || clear) begin
      empty_cnt <= '0;
      black_cnt <= '0;
      white_cnt <= '0;
      invalid <= 1'b0;
    end else if (valid) begin
      empty_cnt <= empty_cnt + CNT_W'(code == CELL_EMPTY);
      black_cnt <= black_cnt + CNT_W'(code == CELL_BLACK);
      white_cnt <= white_cnt + CNT_W'(code == CELL_WHITE);
      invalid <= invalid | (code == CELL_INVALID);
    end
endmodule

// File: rtl/board_scan.sv
// board_scan: reads all board RAM cells in order, streams them out and tallies stones.
module board_scan
  import go_pkg::*;
#(
  parameter int ADDR_W = BOARD_ADDR_W,
  parameter int CNT_W = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [1:0]        ram_rd_data,
  output logic              cell_valid,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [1:0]        cell_data,
  output logic [CNT_W-1:0]  empty_cnt,
  output logic [CNT_W-1:0]  black_cnt,
  output logic [CNT_W-1:0]  white_cnt,
  output logic              invalid,
  output logic              done
);
  scan_state_t state;
  logic start;
  assign start = (state == IDLE) && en && !done;
  assign cell_data = ram_rd_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ram_re <= 1'b0;
      ram_addr <= '0;
      cell_valid <= 1'b0;
      cell_addr <= '0;
      done <= 1'b0;
    end else begin
      cell_valid <= ram_re;
      cell_addr <= ram_addr;
      case (state)
        IDLE:
          if (done && !en) done <= 1'b0;
          else if (start) begin
            state <= READ;
            ram_re <= 1'b1;
            ram_addr <= '0;
          end
        READ:
          if (ram_addr == '1) begin
            state <= DRAIN;
            ram_re <= 1'b0;
          end else ram_addr <= ram_addr + ADDR_W'(1);
        DRAIN: begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  stone_tally #(.CNT_W(CNT_W)) u_tally (
    .clk(clk),
    .rst(rst),
    .clear(start),
    .valid(cell_valid),
    .code(ram_rd_data),
    .empty_cnt(empty_cnt),
    .black_cnt(black_cnt),
    .white_cnt(white_cnt),
    .invalid(invalid)
  );
endmodule

// File: tb/tb_board_scan.sv
// tb_board_scan: directed checks of board_scan against a synchronous RAM model.
module tb_board_scan;
  logic clk = 1'b0;
  logic rst, en, ram_re, cell_valid, invalid, done;
  logic [5:0] ram_addr, cell_addr;
  logic [1:0] ram_rd_data, cell_data;
  logic [6:0] empty_cnt, black_cnt, white_cnt;
  logic [1:0] mem [64];
  int checks = 0;
  int errors = 0;
  board_scan dut (
    .clk(clk), .rst(rst), .en(en), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data), .cell_valid(cell_valid), .cell_addr(cell_addr),
    .cell_data(cell_data), .empty_cnt(empty_cnt), .black_cnt(black_cnt),
    .white_cnt(white_cnt), .invalid(invalid), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_re) ram_rd_data <= mem[ram_addr];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_re"}, ram_re, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_cv"}, cell_valid, 0);
    chk({tag, "_ca"}, cell_addr, 0);
    chk({tag, "_cnts"}, {empty_cnt, black_cnt, white_cnt, invalid}, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  // Starts from en=1 with done=0; drop>0 lowers en just before that edge.
  task automatic scan(input string tag, input int drop, input int e, input int b, input int w, input logic inv);
    logic ok = 1'b1;
    en = 1'b1;
    tick;
    chk({tag, "_start_addr"}, ram_addr, 0);
    chk({tag, "_start_re"}, ram_re, 1);
    chk({tag, "_start_clr"}, {empty_cnt, black_cnt, white_cnt, invalid}, 0);
    for (int k = 1; k <= 64; k++) begin
      if (k == drop) en = 1'b0;
      tick;
      if (k < 64) ok &= (ram_addr == 6'(k)) && ram_re;
      else ok &= (ram_addr == 6'd63) && !ram_re;
      ok &= cell_valid && (cell_addr == 6'(k - 1)) && (cell_data === mem[k - 1]) && !done;
    end
    chk({tag, "_stream"}, ok, 1);
    tick;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cv_off"}, cell_valid, 0);
    chk({tag, "_empty"}, empty_cnt, e);
    chk({tag, "_black"}, black_cnt, b);
    chk({tag, "_white"}, white_cnt, w);
    chk({tag, "_inv"}, invalid, inv);
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    tick;
    tick;
    chk_idle("reset");
    rst = 1'b0;
    tick;
    chk_idle("idle");
    scan("empty", 0, 64, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) tick;
    chk("hold_done", done, 1);
    chk("hold_re", ram_re, 0);
    chk("hold_cnt", empty_cnt, 64);
    en = 1'b0;
    tick;
    chk("hold_clear", done, 0);
    for (int i = 0; i < 64; i++) mem[i] = i[0] ? 2'b10 : 2'b01;
    scan("checker", 0, 0, 32, 32, 1'b0);
    en = 1'b0;
    tick;
    chk("checker_clear", done, 0);
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    mem[17] = 2'b11;
    scan("inv17", 10, 63, 0, 0, 1'b1);
    tick;
    chk("inv17_clear", done, 0);
    chk("inv17_keep", {empty_cnt, invalid}, {7'd63, 1'b1});
    for (int i = 0; i < 64; i++) mem[i] = 2'(i % 3);
    en = 1'b1;
    for (int i = 0; i < 30; i++) tick;
    chk("abort_pre", ram_addr, 29);
    rst = 1'b1;
    tick;
    chk_idle("abort");
    rst = 1'b0;
    en = 1'b0;
    tick;
    chk("abort_nodone", done, 0);
    scan("mod3", 0, 22, 21, 21, 1'b0);
    en = 1'b0;
    tick;
    chk("mod3_clear", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_scan.md
# board_scan

Sequential reader for the 64-cell board RAM: on request it reads every cell from address 0 to 63 and streams each cell out with its address. It also tallies empty, black and white stones, flags reserved codes, and reports completion with the same `en`/`done` handshake as the board-clear writer. It sits on the RAM's read port and feeds score counting and display logic.

## Interface
- `ADDR_W`, 6, board RAM address width; cells = 2**ADDR_W.
- `CNT_W`, `ADDR_W`+1, tally width, holds 0..64.

- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high (fixed decision).
- `en`  in  1  scan request level; a scan starts when `en`=1 and `done`=0 in IDLE.
- `ram_re`  out  ADDR_W-independent 1  RAM read enable.
- `ram_addr`  out  `ADDR_W`  RAM read address.
- `ram_rd_data`  in  2  RAM read data; synchronous RAM, 1-cycle latency.
- `cell_valid`  out  1  streamed cell strobe.
- `cell_addr`  out  `ADDR_W`  address of the streamed cell.
- `cell_data`  out  2  streamed cell code (`ram_rd_data` passed through).
- `empty_cnt`, `black_cnt`, `white_cnt`  out  `CNT_W`  tallies for the last scan.
- `invalid`  out  1  sticky flag: a code of 2'b11 was seen in the last scan.
- `done`  out  1  scan complete; held high until `en` is low.

## Operation
- Cell codes: 2'b00 empty, 2'b01 black, 2'b10 white, 2'b11 reserved/invalid.
- FSM states:
  - IDLE -> READ when `en` && !`done`.
  - READ -> DRAIN after issuing address 63.
  - DRAIN -> IDLE unconditionally.
- IDLE→READ edge:
  - `ram_addr`=0.
  - All tallies cleared.
  - `invalid` cleared.
- READ: `ram_re`=1; `ram_addr` increments by 1 every cycle, 0..63, with no wrap.
- DRAIN: `ram_re`=0; `ram_addr` holds 63. This state exists only to receive the last read datum.
- Streaming:
  - `cell_valid` is `ram_re` delayed one cycle.
  - `cell_addr` is `ram_addr` delayed one cycle.
  - `cell_data` = `ram_rd_data`.
- Tally: on each edge where `cell_valid`=1, increment exactly one of `empty_cnt`/`black_cnt`/`white_cnt`; code 2'b11 sets `invalid` and increments none.
- Width rule: each counter maximum is 64; no saturation logic is needed.
- Invariant at `done` rise: `empty_cnt`+`black_cnt`+`white_cnt`=64 iff `invalid`=0.
- `done`:
  - Set on the DRAIN→IDLE edge.
  - Cleared on the first edge where `done`=1 and `en`=0.
  - A new scan cannot start while `done`=1.
- Tallies and `invalid` hold their values after a scan until the next scan starts.
- `en` falling mid-scan: ignored; the scan runs to completion and `done` still rises. If `en` is already low at that point, `done` clears on the following edge.
- `rst` mid-scan: abort immediately; all state returns to reset values; no `done`.

## Timing
- Reset values: state IDLE, `ram_re`=0, `ram_addr`=0, `cell_valid`=0, `cell_addr`=0, all tallies 0, `invalid`=0, `done`=0.
- Edge 0 is the edge that samples the start condition.
  - After edge k (k=0..63): `ram_addr`=k, `ram_re`=1.
  - After edge 64: state DRAIN.
  - After edge a+1 (a=0..63): `cell_valid`=1, `cell_addr`=a.
  - After edge 65: state IDLE, `done`=1, tallies final.
- Scan latency: 66 cycles from the start edge to `done` visible; 64 RAM reads, back-to-back.
- Minimum start-to-start interval: 66 cycles plus the `done`/`en` handshake, which needs at least one cycle with `en`=0.

## Structure
- Shared package `go_pkg` holds:
  - Cell code constants `CELL_EMPTY`, `CELL_BLACK`, `CELL_WHITE`, `CELL_INVALID`.
  - `BOARD_ADDR_W` = 6.
  - The FSM state typedef with values IDLE, READ, DRAIN.
- One sub-module is natural: `stone_tally`. It takes `clk`, `rst`, `clear`, `valid` and `code`, and outputs the three counters plus `invalid`. The top level keeps the FSM, address counter and stream registers.

## Test plan
- RAM all 2'b00, pulse `en` high and hold → `ram_addr` 0..63 on consecutive cycles; `done`=1 exactly 66 cycles after the start edge; `empty_cnt`=64, `black_cnt`=0, `white_cnt`=0, `invalid`=0.
- Checkerboard (even address black, odd white) → `black_cnt`=32, `white_cnt`=32, `empty_cnt`=0; every `cell_addr`/`cell_data` pair matches the RAM model.
- One cell at address 17 = 2'b11, rest empty → `invalid`=1, `empty_cnt`=63, sum=63.
- `en` held high after `done` → no second scan; `done` stays 1; after `en`=0 for one cycle `done`=0; re-raising `en` starts a scan with tallies cleared to 0 on the start edge.
- `en` dropped at cycle 10 of the scan → scan completes, `done` rises at cycle 66 and clears one cycle later.
- `rst` asserted at cycle 30 of the scan → next cycle all outputs are at reset values, no `done`; a new `en` gives a full, correct 64-cell scan.
